// File: rtl/kuznechik_pkg.sv
// Shared Kuznyechik definitions: block geometry, stage state encoding and the pi tables.
// The inverse table is derived from the forward pi table at elaboration time.
package kuznechik_pkg;

   localparam int BLOCK_W  = 128;
   localparam int BYTE_CNT = 16;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_SUBST = 4'd1,
      ST_DONE  = 4'd2
   } stage_state_t;

   localparam int PI [256] = '{
      252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
      233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
      249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
        5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
      235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
      181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
       21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
       50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
      223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
      224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
      167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
      173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
        7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
      225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
       32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
       89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
   };

   // Byte v of the result holds pi^-1(v), packed so a LUT is a single part-select.
   function automatic logic [2047:0] build_pi_inv();
      logic [2047:0] tbl;
      tbl = '0;
      for (int i = 0; i < 256; i++) begin
         tbl[PI[i]*8 +: 8] = 8'(i);
      end
      return tbl;
   endfunction

   localparam logic [2047:0] PI_INV_TBL = build_pi_inv();

endpackage

// File: rtl/S_convertion_table_revers.sv
// Combinational pi^-1 byte substitution.
module S_convertion_table_revers
   import kuznechik_pkg::*;
(
   input  logic [7:0] byte_in,
   output logic [7:0] byte_out
);

   assign byte_out = PI_INV_TBL[{byte_in, 3'b000} +: 8];

endmodule

// File: rtl/s_convertion_revers.sv
// Inverse S stage: substitutes the 16 bytes of a block through pi^-1, BYTES_PER_CYCLE per clock.
// Result is flagged by finish_convertion until enable drops; latency K+2 edges from the request.
module s_convertion_revers
   import kuznechik_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
)
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [BLOCK_W-1:0] input_word,
   output logic [BLOCK_W-1:0] output_word,
   output logic               finish_convertion
);

   localparam int K       = BYTE_CNT / BYTES_PER_CYCLE;
   localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;
   localparam int CNT_W   = (K > 1) ? $clog2(K) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

   if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
       BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
      $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   stage_state_t       state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLOCK_W-1:0] work_q, work_d;
   logic [BLOCK_W-1:0] output_word_q, output_word_d;
   logic               finish_q, finish_d;
   logic [CHUNK_W-1:0] sub_chunk;
   logic [BLOCK_W-1:0] work_rot;

   for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lut
      S_convertion_table_revers u_lut (
         .byte_in  (work_q[BLOCK_W-1-8*g -: 8]),
         .byte_out (sub_chunk[CHUNK_W-1-8*g -: 8])
      );
   end

   // Top chunk is substituted and rotated to the bottom; after K steps bytes are home again.
   if (CHUNK_W == BLOCK_W) begin : g_rot_full
      assign work_rot = sub_chunk;
   end else begin : g_rot_part
      assign work_rot = {work_q[BLOCK_W-CHUNK_W-1:0], sub_chunk};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         work_q        <= '0;
         output_word_q <= '0;
         finish_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         work_q        <= work_d;
         output_word_q <= output_word_d;
         finish_q      <= finish_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable) state_d = ST_SUBST;
         ST_SUBST: if (cnt_q == CNT_LAST) state_d = ST_DONE;
         ST_DONE:  if (!enable) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d         = cnt_q;
      work_d        = work_q;
      output_word_d = output_word_q;
      finish_d      = finish_q;
      case (state_q)
         ST_IDLE: begin
            finish_d = 1'b0;
            cnt_d    = '0;
            if (enable) work_d = input_word;
         end
         ST_SUBST: begin
            work_d = work_rot;
            if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
         end
         ST_DONE: begin
            output_word_d = work_q;
            finish_d      = 1'b1;
         end
         default: begin
            finish_d = 1'b0;
            cnt_d    = '0;
         end
      endcase
   end

   assign output_word       = output_word_q;
   assign finish_convertion = finish_q;

endmodule

// File: tb/tb_s_convertion_revers.sv
// Randomized bench for s_convertion_revers against a byte-wise pi^-1 model built by inverting pi.
module tb_s_convertion_revers;

   localparam int PI_FWD [256] = '{
      252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
      233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
      249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
        5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
      235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
      181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
       21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
       50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
      223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
      224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
      167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
      173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
        7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
      225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
       32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
       89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
   };

   localparam logic [127:0] GOST_IN  = 128'hb66cd8887d38e8d77765aeea0c9a7efc;
   localparam logic [127:0] GOST_OUT = 128'hffeeddccbbaa99881122334455667700;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               enable;
   logic [127:0]       input_word;
   logic [127:0]       output_word;
   logic               finish_convertion;
   logic               sw_en;
   logic [127:0]       sw_word;
   logic [4:0]         sw_fin;
   logic [4:0][127:0]  sw_out;
   int                 checks = 0;
   int                 errors = 0;

   always #5 clk = ~clk;

   s_convertion_revers #(.BYTES_PER_CYCLE(4)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .enable            (enable),
      .input_word        (input_word),
      .output_word       (output_word),
      .finish_convertion (finish_convertion)
   );

   for (genvar gi = 0; gi < 5; gi++) begin : g_sweep
      s_convertion_revers #(.BYTES_PER_CYCLE(1 << gi)) u_sw (
         .clk               (clk),
         .reset_n           (reset_n),
         .enable            (sw_en),
         .input_word        (sw_word),
         .output_word       (sw_out[gi]),
         .finish_convertion (sw_fin[gi])
      );
   end

   function automatic logic [7:0] inv_byte(input logic [7:0] b);
      for (int i = 0; i < 256; i++) begin
         if (PI_FWD[i] == int'(b)) return 8'(i);
      end
      return 8'h00;
   endfunction

   function automatic logic [127:0] ref_word(input logic [127:0] w);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_byte(w[8*i +: 8]);
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Request with enable held until finish, then for `hold` more cycles, then release.
   task automatic run_conv(input logic [127:0] w, input int hold, input string tag);
      int n;
      logic [127:0] exp;
      exp        = ref_word(w);
      input_word = w;
      enable     = 1'b1;
      n          = 0;
      do begin
         tick();
         n++;
         if (n == 1) input_word = {$urandom(), $urandom(), $urandom(), $urandom()};
      end while (!finish_convertion && n < 40);
      check_eq({tag, "_lat"}, 128'(n), 128'(6));
      check_eq({tag, "_out"}, output_word, exp);
      for (int h = 0; h < hold; h++) begin
         tick();
         check_eq({tag, "_hold_out"}, output_word, exp);
         check_eq({tag, "_hold_fin"}, 128'(finish_convertion), 128'(1));
      end
      enable = 1'b0;
      tick();
      check_eq({tag, "_exit_fin"}, 128'(finish_convertion), 128'(1));
      tick();
      check_eq({tag, "_idle_fin"}, 128'(finish_convertion), 128'(0));
      check_eq({tag, "_idle_out"}, output_word, exp);
   endtask

   task automatic sweep(input logic [127:0] w);
      int first [5];
      logic [127:0] exp;
      exp     = ref_word(w);
      sw_word = w;
      sw_en   = 1'b1;
      for (int v = 0; v < 5; v++) first[v] = 0;
      for (int e = 1; e <= 24; e++) begin
         tick();
         for (int v = 0; v < 5; v++) begin
            if (sw_fin[v] && first[v] == 0) first[v] = e;
         end
      end
      for (int v = 0; v < 5; v++) begin
         check_eq($sformatf("sweep_bpc%0d_lat", 1 << v), 128'(first[v]), 128'(16 / (1 << v) + 2));
         check_eq($sformatf("sweep_bpc%0d_out", 1 << v), sw_out[v], exp);
      end
      sw_en = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int n;
      int fin_seen;
      reset_n    = 1'b0;
      enable     = 1'b1;
      sw_en      = 1'b1;
      input_word = GOST_IN;
      sw_word    = GOST_IN;
      tick();
      tick();
      check_eq("rst_out", output_word, '0);
      check_eq("rst_fin", 128'(finish_convertion), 128'(0));
      check_eq("rst_sw_fin", 128'(sw_fin), 128'(0));
      enable  = 1'b0;
      sw_en   = 1'b0;
      reset_n = 1'b1;
      tick();

      run_conv(GOST_IN, 1, "gost");
      check_eq("gost_const", output_word, GOST_OUT);
      run_conv('0, 0, "zero");
      check_eq("zero_const", output_word, {16{8'ha5}});
      run_conv({16{8'hfc}}, 2, "fc");
      check_eq("fc_const", output_word, '0);
      run_conv({8{16'heeb6}}, 0, "eeb6");
      check_eq("eeb6_const", output_word, {8{16'h01ff}});

      sweep(GOST_IN);
      sweep({$urandom(), $urandom(), $urandom(), $urandom()});

      // enable released right after the loading edge
      input_word = GOST_IN;
      enable     = 1'b1;
      tick();
      enable = 1'b0;
      n      = 1;
      while (!finish_convertion && n < 40) begin
         tick();
         n++;
      end
      check_eq("drop_lat", 128'(n), 128'(6));
      check_eq("drop_out", output_word, GOST_OUT);
      tick();
      check_eq("drop_fin_pulse", 128'(finish_convertion), 128'(0));
      check_eq("drop_keep", output_word, GOST_OUT);
      run_conv(GOST_IN, 0, "after_drop");

      // reset pulse in the middle of a conversion
      input_word = {16{8'h11}};
      enable     = 1'b1;
      tick();
      enable = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_eq("midrst_out", output_word, '0);
      check_eq("midrst_fin", 128'(finish_convertion), 128'(0));
      fin_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (finish_convertion) fin_seen++;
      end
      check_eq("midrst_no_fin", 128'(fin_seen), 128'(0));
      check_eq("midrst_out_hold", output_word, '0);
      run_conv(GOST_IN, 0, "post_rst");

      run_conv(128'h0123456789abcdef_fedcba9876543210, 2, "b2b_a");
      run_conv(128'h5a5a5a5a_c3c3c3c3_00ff00ff_deadbeef, 1, "b2b_b");

      for (int i = 0; i < 1000; i++) begin
         run_conv({$urandom(), $urandom(), $urandom(), $urandom()}, int'($urandom_range(0, 3)), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
